// File: rtl/fifo_pkg.sv
// Shared dual-clock FIFO definitions: default geometry, pointer width rule
// and the binary-to-Gray helper used by both pointer domains.
package fifo_pkg;

    localparam int FIFO_ASIZE_DEF     = 4;
    localparam int FIFO_AE_THRESH_DEF = 2;

    // Pointers carry one extra MSB so full and empty can be told apart
    function automatic int ptr_w(input int asize);
        return asize + 1;
    endfunction

    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

endpackage

// File: rtl/gray2bin.sv
// Combinational Gray-to-binary converter: each binary bit is the XOR of
// all Gray bits at or above its position.
module gray2bin #(
    parameter int W = 5
) (
    input  logic [W-1:0] gray,
    output logic [W-1:0] bin
);

    assign bin[W-1] = gray[W-1];

    for (genvar i = 0; i < W - 1; i++) begin : g_bit
        assign bin[i] = ^(gray >> i);
    end

endmodule

// File: rtl/rptr_empty_ctrl.sv
// Read-side pointer, empty/almost-empty flags and fill level for the dual-clock FIFO.
// Optional sticky underflow flag enabled by defining RPTR_EMPTY_UNDERFLOW_EN.
module rptr_empty_ctrl
    import fifo_pkg::*;
#(
    parameter int ASIZE     = FIFO_ASIZE_DEF,
    parameter int AE_THRESH = FIFO_AE_THRESH_DEF
) (
    input  logic             rclk,
    input  logic             rrst_n,
    input  logic             rinc,
    input  logic [ASIZE:0]   wptr_sync,
    output logic [ASIZE:0]   rptr,
    output logic [ASIZE-1:0] raddr,
    output logic [ASIZE:0]   rlevel,
    output logic             aempty,
    output logic             rempty,
    output logic             underflow
);

    localparam int PTR_W = ptr_w(ASIZE);

    logic [PTR_W-1:0] rbin;
    logic [PTR_W-1:0] rbnext;
    logic [PTR_W-1:0] rgnext;
    logic [PTR_W-1:0] wbin_s;
    logic [PTR_W-1:0] rlevel_n;

    gray2bin #(
        .W (PTR_W)
    ) u_wptr_g2b (
        .gray (wptr_sync),
        .bin  (wbin_s)
    );

    // Flags look at the next pointer so the emptying read raises rempty on the very next edge
    always_comb begin
        rbnext   = rbin + PTR_W'(rinc & ~rempty);
        rgnext   = PTR_W'(bin2gray(32'(rbnext)));
        rlevel_n = wbin_s - rbnext;
    end

    assign raddr = rbin[ASIZE-1:0];

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            rbin   <= '0;
            rptr   <= '0;
            rlevel <= '0;
            rempty <= 1'b1;
            aempty <= 1'b1;
        end else begin
            rbin   <= rbnext;
            rptr   <= rgnext;
            rlevel <= rlevel_n;
            rempty <= (rgnext == wptr_sync);
            aempty <= (rlevel_n <= PTR_W'(AE_THRESH));
        end
    end

`ifdef RPTR_EMPTY_UNDERFLOW_EN
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            underflow <= 1'b0;
        end else begin
            underflow <= underflow | (rinc & rempty);
        end
    end
`else
    assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_rptr_empty_ctrl.sv
// Self-checking bench for rptr_empty_ctrl (ASIZE=4, AE_THRESH=2) with a
// level-based reference model and directed pointer/wrap/reset scenarios.
module tb_rptr_empty_ctrl;

    logic       rclk = 1'b0;
    logic       rrst_n = 1'b1;
    logic       rinc = 1'b0;
    logic [4:0] wptr_sync = '0;
    logic [4:0] rptr;
    logic [3:0] raddr;
    logic [4:0] rlevel;
    logic       aempty;
    logic       rempty;
    logic       underflow;

    int n_checks = 0;
    int n_fail   = 0;
    bit check_en = 1'b0;

    // Reference model: read count, fill level and flags derived from the level
    int m_rbin   = 0;
    int m_level  = 0;
    int m_w      = 0;
    bit m_acc    = 1'b0;
    bit m_empty  = 1'b1;
    bit m_aempty = 1'b1;
    bit m_uf     = 1'b0;

    rptr_empty_ctrl #(
        .ASIZE     (4),
        .AE_THRESH (2)
    ) dut (
        .rclk      (rclk),
        .rrst_n    (rrst_n),
        .rinc      (rinc),
        .wptr_sync (wptr_sync),
        .rptr      (rptr),
        .raddr     (raddr),
        .rlevel    (rlevel),
        .aempty    (aempty),
        .rempty    (rempty),
        .underflow (underflow)
    );

    always #5 rclk = ~rclk;

    function automatic int gray_decode(input logic [4:0] g);
        for (int b = 0; b < 32; b++) begin
            if (5'((b ^ (b >> 1)) & 31) == g) return b;
        end
        return -1;
    endfunction

    function automatic logic [4:0] to_gray(input int b);
        return 5'((b ^ (b >> 1)) & 31);
    endfunction

    always @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            m_rbin   = 0;
            m_level  = 0;
            m_empty  = 1'b1;
            m_aempty = 1'b1;
            m_uf     = 1'b0;
        end else begin
            m_acc = rinc && !m_empty;
`ifdef RPTR_EMPTY_UNDERFLOW_EN
            if (rinc && m_empty) m_uf = 1'b1;
`endif
            m_rbin   = (m_rbin + int'(m_acc)) % 32;
            m_w      = gray_decode(wptr_sync);
            m_level  = (m_w - m_rbin + 32) % 32;
            m_empty  = (m_level == 0);
            m_aempty = (m_level <= 2);
        end
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Drive on the falling edge, return 1 time unit after the following rising edge
    task automatic applyStimulus(input logic rinc_v, input logic [4:0] wptr_v);
        @(negedge rclk);
        rinc      = rinc_v;
        wptr_sync = wptr_v;
        @(posedge rclk);
        #1;
    endtask

    always @(negedge rclk) begin
        if (check_en && rrst_n === 1'b1) begin
            checkOutput("cyc_rptr",      int'(rptr),      int'(to_gray(m_rbin)));
            checkOutput("cyc_raddr",     int'(raddr),     m_rbin % 16);
            checkOutput("cyc_rlevel",    int'(rlevel),    m_level);
            checkOutput("cyc_rempty",    int'(rempty),    int'(m_empty));
            checkOutput("cyc_aempty",    int'(aempty),    int'(m_aempty));
            checkOutput("cyc_underflow", int'(underflow), int'(m_uf));
        end
    end

    initial begin
        int uf_exp;
`ifdef RPTR_EMPTY_UNDERFLOW_EN
        uf_exp = 1;
`else
        uf_exp = 0;
`endif
        // Asynchronous reset with no clock edge
        #1 rrst_n = 1'b0;
        #1;
        checkOutput("rst_rptr",      int'(rptr),      0);
        checkOutput("rst_raddr",     int'(raddr),     0);
        checkOutput("rst_rlevel",    int'(rlevel),    0);
        checkOutput("rst_rempty",    int'(rempty),    1);
        checkOutput("rst_aempty",    int'(aempty),    1);
        checkOutput("rst_underflow", int'(underflow), 0);
        @(negedge rclk);
        @(negedge rclk);
        rrst_n   = 1'b1;
        check_en = 1'b1;

        // Three entries become visible
        applyStimulus(1'b0, 5'b00010);
        checkOutput("fill3_rempty", int'(rempty), 0);
        checkOutput("fill3_rlevel", int'(rlevel), 3);
        checkOutput("fill3_aempty", int'(aempty), 0);
        checkOutput("fill3_raddr",  int'(raddr),  0);

        // Drain them
        applyStimulus(1'b1, 5'b00010);
        checkOutput("rd1_raddr",  int'(raddr),  1);
        checkOutput("rd1_rlevel", int'(rlevel), 2);
        checkOutput("rd1_aempty", int'(aempty), 1);
        checkOutput("rd1_rempty", int'(rempty), 0);
        applyStimulus(1'b1, 5'b00010);
        checkOutput("rd2_raddr",  int'(raddr),  2);
        checkOutput("rd2_rlevel", int'(rlevel), 1);
        applyStimulus(1'b1, 5'b00010);
        checkOutput("rd3_raddr",  int'(raddr),  3);
        checkOutput("rd3_rlevel", int'(rlevel), 0);
        checkOutput("rd3_rempty", int'(rempty), 1);

        // Reads while empty are ignored
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 5'b00010);
        checkOutput("uf_rptr",      int'(rptr),      2);
        checkOutput("uf_raddr",     int'(raddr),     3);
        checkOutput("uf_underflow", int'(underflow), uf_exp);
        applyStimulus(1'b0, 5'b00010);
        checkOutput("uf_sticky",    int'(underflow), uf_exp);

        // Walk the read pointer up to binary 31
        applyStimulus(1'b0, 5'b10000);
        for (int i = 0; i < 28; i++) applyStimulus(1'b1, 5'b10000);
        checkOutput("walk_rptr",   int'(rptr),   5'b10000);
        checkOutput("walk_rempty", int'(rempty), 1);
        applyStimulus(1'b0, 5'b11000);
        checkOutput("wrap_pre_rempty", int'(rempty), 0);
        applyStimulus(1'b1, 5'b11000);
        checkOutput("wrap_rptr",   int'(rptr),   0);
        checkOutput("wrap_raddr",  int'(raddr),  0);
        checkOutput("wrap_rlevel", int'(rlevel), 16);
        checkOutput("wrap_rempty", int'(rempty), 0);
        checkOutput("wrap_aempty", int'(aempty), 0);
        applyStimulus(1'b0, 5'b00000);
        checkOutput("wrap_zero_rempty", int'(rempty), 1);
        checkOutput("wrap_zero_rlevel", int'(rlevel), 0);

        // Mid-stream reset with five entries visible
        applyStimulus(1'b0, 5'b00111);
        checkOutput("mid_rlevel", int'(rlevel), 5);
        @(negedge rclk);
        #2 rrst_n = 1'b0;
        #1;
        checkOutput("mid_rst_rptr",      int'(rptr),      0);
        checkOutput("mid_rst_raddr",     int'(raddr),     0);
        checkOutput("mid_rst_rlevel",    int'(rlevel),    0);
        checkOutput("mid_rst_rempty",    int'(rempty),    1);
        checkOutput("mid_rst_aempty",    int'(aempty),    1);
        checkOutput("mid_rst_underflow", int'(underflow), 0);
        @(negedge rclk);
        rrst_n = 1'b1;
        applyStimulus(1'b0, 5'b00111);
        checkOutput("post_rlevel", int'(rlevel), 5);
        checkOutput("post_raddr",  int'(raddr),  0);
        applyStimulus(1'b1, 5'b00111);
        checkOutput("post_rd_raddr",  int'(raddr),  1);
        checkOutput("post_rd_rlevel", int'(rlevel), 4);
        applyStimulus(1'b0, 5'b00111);

        @(negedge rclk);
        check_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
